// File: rtl/dual_mem_port_arbiter.sv
// dual_mem_port_arbiter
// Shares the single DRAM/peripheral port between the MEM stages of the two
// issue lanes. Lane0 is always the older instruction, so it goes first on a
// conflict. Lane1 follows one cycle later, and the pipeline is frozen for
// that one cycle. Conflicts are counted in a saturating counter.
module dual_mem_port_arbiter #(
    parameter int          CNT_W     = 32,
    parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             l0_req,
    input  logic             l0_wen,
    input  logic [31:0]      l0_addr,
    input  logic [2:0]       l0_mask,
    input  logic [31:0]      l0_wdata,
    output logic [31:0]      l0_rdata,

    input  logic             l1_req,
    input  logic             l1_wen,
    input  logic [31:0]      l1_addr,
    input  logic [2:0]       l1_mask,
    input  logic [31:0]      l1_wdata,
    output logic [31:0]      l1_rdata,

    input  logic             flush,
    output logic             mem_stall,

    output logic [31:0]      perip_addr,
    output logic             perip_wen,
    output logic [2:0]       perip_mask,
    output logic [31:0]      perip_wdata,
    input  logic [31:0]      perip_rdata,

    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e             state_q, state_d;
    logic [31:0]        holdRdata_q, holdRdata_d;
    logic [CNT_W-1:0]   conflictCnt_q, conflictCnt_d;

    logic               bothReq;

    assign bothReq      = l0_req & l1_req;
    assign conflict_cnt = conflictCnt_q;

    // Next-state logic: a dual request in IDLE captures lane0's load data and moves to SECOND.
    always_comb begin
        state_d       = state_q;
        holdRdata_d   = holdRdata_q;
        conflictCnt_d = conflictCnt_q;
        case (state_q)
            IDLE: begin
                if (bothReq) begin
                    state_d     = SECOND;
                    holdRdata_d = perip_rdata;
                    if (conflictCnt_q != '1) begin
                        conflictCnt_d = conflictCnt_q + CNT_ONE;
                    end
                end
            end
            SECOND: begin
                // Lane1 is always finished here, whether or not it was flushed.
                // l0_req is still high only because the pipeline was frozen.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Port steering and load-data return; reset forces writes, stalls and load data low.
    always_comb begin
        perip_addr  = IDLE_ADDR;
        perip_wen   = 1'b0;
        perip_mask  = 3'b000;
        perip_wdata = 32'h0;
        l0_rdata    = 32'h0;
        l1_rdata    = 32'h0;
        mem_stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (l0_req) begin
                    perip_addr  = l0_addr;
                    perip_wen   = l0_wen;
                    perip_mask  = l0_mask;
                    perip_wdata = l0_wdata;
                    l0_rdata    = perip_rdata;
                    mem_stall   = l1_req;
                end else if (l1_req) begin
                    perip_addr  = l1_addr;
                    perip_wen   = l1_wen;
                    perip_mask  = l1_mask;
                    perip_wdata = l1_wdata;
                    l1_rdata    = perip_rdata;
                end
            end
            SECOND: begin
                perip_addr  = l1_addr;
                perip_wen   = l1_wen & ~flush;
                perip_mask  = l1_mask;
                perip_wdata = l1_wdata;
                l0_rdata    = holdRdata_q;
                l1_rdata    = flush ? 32'h0 : perip_rdata;
            end
            default: begin
                perip_addr = IDLE_ADDR;
            end
        endcase
        if (!rst_n) begin
            perip_wen = 1'b0;
            mem_stall = 1'b0;
            l0_rdata  = 32'h0;
            l1_rdata  = 32'h0;
        end
    end

    // State, held lane0 data and the conflict counter; async reset abandons any pending lane1 access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            holdRdata_q   <= 32'h0;
            conflictCnt_q <= '0;
        end else begin
            state_q       <= state_d;
            holdRdata_q   <= holdRdata_d;
            conflictCnt_q <= conflictCnt_d;
        end
    end

endmodule

// File: tb/tb_dual_mem_port_arbiter.sv
// tb_dual_mem_port_arbiter
// Table-driven check of the dual-lane memory port arbiter against a small
// word-addressed memory model. A few hand-written sequences cover reset in
// SECOND and counter saturation.
module tb_dual_mem_port_arbiter;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             l0_req, l0_wen, l1_req, l1_wen, flush;
    logic [31:0]      l0_addr, l0_wdata, l1_addr, l1_wdata;
    logic [2:0]       l0_mask, l1_mask;
    logic [31:0]      l0_rdata, l1_rdata;
    logic             mem_stall;
    logic [31:0]      perip_addr, perip_wdata, perip_rdata;
    logic             perip_wen;
    logic [2:0]       perip_mask;
    logic [CNT_W-1:0] conflict_cnt;

    logic [31:0]      mem [0:255];
    logic             memInit;

    int compareCnt;
    int mismatchCnt;

    typedef struct {
        logic        l0Req;
        logic        l0Wen;
        logic [31:0] l0Addr;
        logic [31:0] l0Wdata;
        logic        l1Req;
        logic        l1Wen;
        logic [31:0] l1Addr;
        logic [31:0] l1Wdata;
        logic        flush;
        logic [31:0] expAddr;
        logic        expWen;
        logic [2:0]  expMask;
        logic [31:0] expWdata;
        logic        expStall;
        logic [31:0] expR0;
        logic [31:0] expR1;
        logic [31:0] expCnt;
    } vec_t;

    vec_t vecs[$];

    dual_mem_port_arbiter #(
        .CNT_W     (CNT_W),
        .IDLE_ADDR (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .l0_req       (l0_req),
        .l0_wen       (l0_wen),
        .l0_addr      (l0_addr),
        .l0_mask      (l0_mask),
        .l0_wdata     (l0_wdata),
        .l0_rdata     (l0_rdata),
        .l1_req       (l1_req),
        .l1_wen       (l1_wen),
        .l1_addr      (l1_addr),
        .l1_mask      (l1_mask),
        .l1_wdata     (l1_wdata),
        .l1_rdata     (l1_rdata),
        .flush        (flush),
        .mem_stall    (mem_stall),
        .perip_addr   (perip_addr),
        .perip_wen    (perip_wen),
        .perip_mask   (perip_mask),
        .perip_wdata  (perip_wdata),
        .perip_rdata  (perip_rdata),
        .conflict_cnt (conflict_cnt)
    );

    // Free-running core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational-read memory behind the shared port.
    assign perip_rdata = mem[perip_addr[9:2]];

    // Memory preload on memInit, otherwise a write on every clock with perip_wen high.
    always @(posedge clk or posedge memInit) begin
        if (memInit) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[64] <= 32'hDEADBEEF;
            mem[4]  <= 32'h11111111;
            mem[8]  <= 32'h22222222;
            mem[16] <= 32'h44444444;
            mem[24] <= 32'h66666666;
            mem[32] <= 32'h80808080;
            mem[33] <= 32'h84848484;
        end else if (perip_wen) begin
            mem[perip_addr[9:2]] <= perip_wdata;
        end
    end

    // One comparison; mismatches are reported and counted.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCnt++;
        if (actual !== expected) begin
            mismatchCnt++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Drive all lane inputs; masks are fixed per lane so pass-through is visible.
    task automatic applyStimulus(input vec_t v);
        l0_req   = v.l0Req;
        l0_wen   = v.l0Wen;
        l0_addr  = v.l0Addr;
        l0_mask  = 3'd2;
        l0_wdata = v.l0Wdata;
        l1_req   = v.l1Req;
        l1_wen   = v.l1Wen;
        l1_addr  = v.l1Addr;
        l1_mask  = 3'd5;
        l1_wdata = v.l1Wdata;
        flush    = v.flush;
    endtask

    task automatic addVec(
        input logic l0r, input logic l0w, input logic [31:0] l0a, input logic [31:0] l0d,
        input logic l1r, input logic l1w, input logic [31:0] l1a, input logic [31:0] l1d,
        input logic fl,
        input logic [31:0] eAddr, input logic eWen, input logic [2:0] eMask, input logic [31:0] eWdata,
        input logic eStall, input logic [31:0] eR0, input logic [31:0] eR1, input logic [31:0] eCnt);
        vec_t v;
        v.l0Req = l0r; v.l0Wen = l0w; v.l0Addr = l0a; v.l0Wdata = l0d;
        v.l1Req = l1r; v.l1Wen = l1w; v.l1Addr = l1a; v.l1Wdata = l1d;
        v.flush = fl;
        v.expAddr = eAddr; v.expWen = eWen; v.expMask = eMask; v.expWdata = eWdata;
        v.expStall = eStall; v.expR0 = eR0; v.expR1 = eR1; v.expCnt = eCnt;
        vecs.push_back(v);
    endtask

    task automatic driveLanes(input logic l0r, input logic l0w, input logic [31:0] l0a,
                              input logic l1r, input logic l1w, input logic [31:0] l1a,
                              input logic [31:0] l1d);
        vec_t v;
        v = '{default: '0};
        v.l0Req = l0r; v.l0Wen = l0w; v.l0Addr = l0a; v.l0Wdata = 32'h0A0A0A0A;
        v.l1Req = l1r; v.l1Wen = l1w; v.l1Addr = l1a; v.l1Wdata = l1d;
        applyStimulus(v);
    endtask

    // Main test sequence.
    initial begin
        vec_t v;
        compareCnt  = 0;
        mismatchCnt = 0;
        memInit     = 1'b0;
        rst_n       = 1'b0;
        driveLanes(1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 32'h55555555);
        #1 memInit = 1'b1;
        #1 memInit = 1'b0;
        #1;
        checkOutput("rst.wen",   {31'h0, perip_wen}, 32'h0);
        checkOutput("rst.stall", {31'h0, mem_stall}, 32'h0);
        checkOutput("rst.r0",    l0_rdata, 32'h0);
        checkOutput("rst.r1",    l1_rdata, 32'h0);
        checkOutput("rst.cnt",   32'(conflict_cnt), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        driveLanes(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        //      l0r  l0w  l0a    l0d            l1r  l1w  l1a    l1d            fl  | addr   wen  mask  wdata          stall r0             r1             cnt
        addVec(1'b1,1'b0,32'h100,32'h0A0A0A0A, 1'b0,1'b0,32'h0,  32'h0,         1'b0, 32'h100,1'b0,3'd2,32'h0A0A0A0A, 1'b0, 32'hDEADBEEF, 32'h0,         32'd0);
        addVec(1'b0,1'b0,32'h0,  32'h0,        1'b0,1'b0,32'h0,  32'h0,         1'b0, 32'h0,  1'b0,3'd0,32'h0,        1'b0, 32'h0,        32'h0,         32'd0);
        addVec(1'b0,1'b0,32'h0,  32'h0,        1'b1,1'b0,32'h20, 32'h0B0B0B0B,  1'b0, 32'h20, 1'b0,3'd5,32'h0B0B0B0B, 1'b0, 32'h0,        32'h22222222,  32'd0);
        addVec(1'b1,1'b0,32'h10, 32'h0A0A0A0A, 1'b1,1'b0,32'h20, 32'h0B0B0B0B,  1'b0, 32'h10, 1'b0,3'd2,32'h0A0A0A0A, 1'b1, 32'h11111111, 32'h0,         32'd0);
        addVec(1'b1,1'b0,32'h10, 32'h0A0A0A0A, 1'b1,1'b0,32'h20, 32'h0B0B0B0B,  1'b0, 32'h20, 1'b0,3'd5,32'h0B0B0B0B, 1'b0, 32'h11111111, 32'h22222222,  32'd1);
        addVec(1'b1,1'b1,32'h40, 32'hCAFEF00D, 1'b1,1'b0,32'h40, 32'h0B0B0B0B,  1'b0, 32'h40, 1'b1,3'd2,32'hCAFEF00D, 1'b1, 32'h44444444, 32'h0,         32'd1);
        addVec(1'b1,1'b1,32'h40, 32'hCAFEF00D, 1'b1,1'b0,32'h40, 32'h0B0B0B0B,  1'b0, 32'h40, 1'b0,3'd5,32'h0B0B0B0B, 1'b0, 32'h44444444, 32'hCAFEF00D,  32'd2);
        addVec(1'b1,1'b0,32'h10, 32'h0A0A0A0A, 1'b0,1'b0,32'h0,  32'h0,         1'b1, 32'h10, 1'b0,3'd2,32'h0A0A0A0A, 1'b0, 32'h11111111, 32'h0,         32'd2);
        addVec(1'b1,1'b0,32'h100,32'h0A0A0A0A, 1'b1,1'b1,32'h80, 32'h12345678,  1'b0, 32'h100,1'b0,3'd2,32'h0A0A0A0A, 1'b1, 32'hDEADBEEF, 32'h0,         32'd2);
        addVec(1'b1,1'b0,32'h100,32'h0A0A0A0A, 1'b1,1'b1,32'h80, 32'h12345678,  1'b1, 32'h80, 1'b0,3'd5,32'h12345678, 1'b0, 32'hDEADBEEF, 32'h0,         32'd3);
        addVec(1'b0,1'b0,32'h0,  32'h0,        1'b1,1'b0,32'h80, 32'h0B0B0B0B,  1'b0, 32'h80, 1'b0,3'd5,32'h0B0B0B0B, 1'b0, 32'h0,        32'h80808080,  32'd3);
        addVec(1'b1,1'b1,32'h60, 32'hAAAA0000, 1'b1,1'b1,32'h60, 32'hBBBB0000,  1'b0, 32'h60, 1'b1,3'd2,32'hAAAA0000, 1'b1, 32'h66666666, 32'h0,         32'd3);
        addVec(1'b1,1'b1,32'h60, 32'hAAAA0000, 1'b1,1'b1,32'h60, 32'hBBBB0000,  1'b0, 32'h60, 1'b1,3'd5,32'hBBBB0000, 1'b0, 32'h66666666, 32'hAAAA0000,  32'd4);
        addVec(1'b1,1'b0,32'h60, 32'h0A0A0A0A, 1'b0,1'b0,32'h0,  32'h0,         1'b0, 32'h60, 1'b0,3'd2,32'h0A0A0A0A, 1'b0, 32'hBBBB0000, 32'h0,         32'd4);
        addVec(1'b0,1'b0,32'h0,  32'h0,        1'b0,1'b0,32'h0,  32'h0,         1'b0, 32'h0,  1'b0,3'd0,32'h0,        1'b0, 32'h0,        32'h0,         32'd4);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #2;
            v = vecs[i];
            checkOutput($sformatf("v%0d.addr", i),  perip_addr,            v.expAddr);
            checkOutput($sformatf("v%0d.wen", i),   {31'h0, perip_wen},    {31'h0, v.expWen});
            checkOutput($sformatf("v%0d.mask", i),  {29'h0, perip_mask},   {29'h0, v.expMask});
            checkOutput($sformatf("v%0d.wdata", i), perip_wdata,           v.expWdata);
            checkOutput($sformatf("v%0d.stall", i), {31'h0, mem_stall},    {31'h0, v.expStall});
            checkOutput($sformatf("v%0d.r0", i),    l0_rdata,              v.expR0);
            checkOutput($sformatf("v%0d.r1", i),    l1_rdata,              v.expR1);
            checkOutput($sformatf("v%0d.cnt", i),   32'(conflict_cnt),     v.expCnt);
        end

        // Reset asserted while lane1's store to 0x84 is pending in SECOND.
        @(negedge clk);
        driveLanes(1'b1, 1'b0, 32'h10, 1'b1, 1'b1, 32'h84, 32'h99999999);
        #2;
        checkOutput("rs.first.stall", {31'h0, mem_stall}, 32'h1);
        @(negedge clk);
        #2;
        checkOutput("rs.second.wen", {31'h0, perip_wen}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rs.wen",   {31'h0, perip_wen}, 32'h0);
        checkOutput("rs.stall", {31'h0, mem_stall}, 32'h0);
        checkOutput("rs.r0",    l0_rdata, 32'h0);
        checkOutput("rs.r1",    l1_rdata, 32'h0);
        checkOutput("rs.cnt",   32'(conflict_cnt), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rs.nowrite", mem[33], 32'h84848484);
        @(negedge clk);
        rst_n = 1'b1;
        driveLanes(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        checkOutput("rs.idleaddr", perip_addr, 32'h0);
        checkOutput("rs.idlestall", {31'h0, mem_stall}, 32'h0);
        @(negedge clk);
        driveLanes(1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        checkOutput("rs.after.stall", {31'h0, mem_stall}, 32'h0);
        checkOutput("rs.after.r0", l0_rdata, 32'h11111111);

        // Seventeen back-to-back dual requests; the 4-bit counter must stop at 4'hF.
        @(negedge clk);
        rst_n = 1'b0;
        driveLanes(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            driveLanes(1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
            #2;
            checkOutput($sformatf("sat%0d.stall1", k), {31'h0, mem_stall}, 32'h1);
            @(negedge clk);
            #2;
            checkOutput($sformatf("sat%0d.stall2", k), {31'h0, mem_stall}, 32'h0);
            checkOutput($sformatf("sat%0d.cnt", k), 32'(conflict_cnt), (k > 15) ? 32'd15 : 32'(k));
        end
        checkOutput("sat.final", 32'(conflict_cnt), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
        $finish;
    end

endmodule
